// File: rtl/plab2_proc_imul_arbiter_if.sv
// plab2_proc_imul_arbiter_if
// Bundles the requester-side and multiplier-side val/rdy channels of the
// imul arbiter.
//   req_val/req_rdy/req_msg     : p_num_reqs request channels (packed msgs)
//   resp_val/resp_rdy/resp_msg  : p_num_reqs response channels, msg broadcast
//   mul_req_*                   : granted request to the shared multiplier
//   mul_resp_*                  : result from the shared multiplier
// Modports: slave = arbiter view, master = environment view.
interface plab2_proc_imul_arbiter_if #(
    parameter int unsigned p_num_reqs   = 2,
    parameter int unsigned p_req_nbits  = 67,
    parameter int unsigned p_resp_nbits = 32
);
    logic [p_num_reqs-1:0]             req_val;
    logic [p_num_reqs-1:0]             req_rdy;
    logic [p_num_reqs*p_req_nbits-1:0] req_msg;
    logic [p_num_reqs-1:0]             resp_val;
    logic [p_num_reqs-1:0]             resp_rdy;
    logic [p_resp_nbits-1:0]           resp_msg;
    logic                              mul_req_val;
    logic                              mul_req_rdy;
    logic [p_req_nbits-1:0]            mul_req_msg;
    logic                              mul_resp_val;
    logic                              mul_resp_rdy;
    logic [p_resp_nbits-1:0]           mul_resp_msg;

    modport slave (
        input  req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
        output req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
    );

    modport master (
        output req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
        input  req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
    );
endinterface

// File: rtl/plab2_proc_imul_arbiter.sv
// plab2_proc_imul_arbiter
// Shares one iterative multiplier (single op in flight) among p_num_reqs
// requesters. Round-robin grant in IDLE; the winner is latched as owner and
// the response is steered back only to it.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (0 = reset)
//   bus    : plab2_proc_imul_arbiter_if.slave (requester + multiplier val/rdy)
// Optional (macro PLAB2_PROC_IMUL_ARB_STATS_EN):
//   stats_busy_cycles : cycles spent in BUSY
//   stats_conflicts   : request fires with 2 or more requesters valid
module plab2_proc_imul_arbiter #(
    parameter int unsigned p_num_reqs   = 2,
    parameter int unsigned p_req_nbits  = 67,
    parameter int unsigned p_resp_nbits = 32
) (
    input  logic clk,
    input  logic reset,
    plab2_proc_imul_arbiter_if.slave bus
`ifdef PLAB2_PROC_IMUL_ARB_STATS_EN
    ,
    output logic [31:0] stats_busy_cycles,
    output logic [31:0] stats_conflicts
`endif
);

    localparam int unsigned c_ptr_nbits = $clog2(p_num_reqs);

    typedef logic [c_ptr_nbits-1:0] ptr_t;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;
    ptr_t   rr_ptr, owner, grant;
    logic   any_val, req_fire, resp_fire;

    function automatic ptr_t wrap_add(input ptr_t p, input int unsigned k);
        return ptr_t'((32'(p) + k) % p_num_reqs);
    endfunction

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant   = rr_ptr;
        any_val = 1'b0;
        for (int unsigned k = 0; k < p_num_reqs; k++) begin
            if (!any_val && bus.req_val[wrap_add(rr_ptr, k)]) begin
                grant   = wrap_add(rr_ptr, k);
                any_val = 1'b1;
            end
        end
    end

    assign req_fire  = (state == IDLE) && bus.mul_req_val  && bus.mul_req_rdy;
    assign resp_fire = (state == BUSY) && bus.mul_resp_val && bus.mul_resp_rdy;

    // State register plus the owner / pointer captured on a request fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                owner  <= grant;
                rr_ptr <= wrap_add(grant, 1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire)  state_next = BUSY;
            BUSY:    if (resp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy      = '0;
        bus.resp_val     = '0;
        bus.mul_req_val  = 1'b0;
        bus.mul_resp_rdy = 1'b0;
        bus.mul_req_msg  = bus.req_msg[32'(grant)*p_req_nbits +: p_req_nbits];
        bus.resp_msg     = bus.mul_resp_msg;
        if (reset) begin
            case (state)
                IDLE: begin
                    // A response with no owner is drained before any new issue.
                    if (bus.mul_resp_val) begin
                        bus.mul_resp_rdy = 1'b1;
                    end else begin
                        bus.mul_req_val    = any_val;
                        bus.req_rdy[grant] = bus.mul_req_rdy & any_val;
                    end
                end
                BUSY: begin
                    bus.resp_val[owner] = bus.mul_resp_val;
                    bus.mul_resp_rdy    = bus.resp_rdy[owner];
                end
                default: ;
            endcase
        end
    end

`ifdef PLAB2_PROC_IMUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats_busy_cycles <= '0;
            stats_conflicts   <= '0;
        end else begin
            if (state == BUSY)
                stats_busy_cycles <= stats_busy_cycles + 32'd1;
            if (req_fire && ($countones(bus.req_val) >= 2))
                stats_conflicts <= stats_conflicts + 32'd1;
        end
    end
`endif

endmodule
